mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Memory-stage load/store unit and MEM/WB pipeline register. It is the consumer of the EXE stage outputs: ALU result/address, store data, funct3 and control bits.
- Drives a ready-handshaked data-memory port.
- Formats store bytes and sign/zero-extends loads.
- Presents registered results to WB.
- Stalls upstream while a memory access is outstanding.

Parameters:
DATA_WIDTH, 32, datapath and memory data width
ADDR_WIDTH, 32, memory address width
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EXE/MEM slot holds a valid instruction
ex_flush  in  1  kill the instruction currently offered (IDLE only)
ex_alu_o  in  DATA_WIDTH  ALU result; also the load/store address
ex_wb_data  in  DATA_WIDTH  non-memory writeback value (ALU_o or PC+4, already selected)
ex_rs2  in  DATA_WIDTH  store data (post-forwarding)
ex_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
ex_mem_read  in  1  load
ex_mem_write  in  1  store
ex_reg_write  in  1  instruction writes rd
ex_rd  in  REG_ADDR_W  destination register
stall_o  out  1  hold EXE/MEM inputs stable
mem_req  out  1  memory request valid
mem_we  out  1  1 = write
mem_addr  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00})
mem_wdata  out  DATA_WIDTH  lane-replicated store data
mem_wstrb  out  4  byte strobes
mem_ready  in  1  memory completes request this cycle
mem_rdata  in  DATA_WIDTH  read data, valid when mem_ready
wb_valid  out  1  WB slot valid
wb_reg_write  out  1  write rd in WB
wb_rd  out  REG_ADDR_W  destination register
wb_data  out  DATA_WIDTH  writeback value
wb_misalign  out  1  misaligned access flagged, one-cycle pulse with wb_valid

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output 0. This includes mem_req, all mem_* buses, all wb_* outputs and stall_o. Reset mid-access drops mem_req immediately and abandons the access.
- FSM states: IDLE, REQ.
- stall_o = (state==REQ), combinational.
- IDLE, accept = ex_valid & ~ex_flush:
  - Non-memory op: next edge loads WB regs with wb_valid=1, wb_data=ex_wb_data, wb_reg_write=ex_reg_write, wb_rd=ex_rd. State stays IDLE. Latency 1.
  - Memory op, aligned: next edge latches address, strobes, wdata, funct3, rd, reg_write and we; goes to REQ. WB regs load wb_valid=0 (bubble).
  - Memory op, misaligned: no request is issued. Next edge loads wb_valid=1, wb_misalign=1, wb_reg_write=0.
    - Misaligned H/HU: addr[0]!=0.
    - Misaligned W: addr[1:0]!=0.
  - No accept: wb_valid=0 next edge.
- ex_mem_read and ex_mem_write both set: treated as a store.
- REQ:
  - mem_req=1; mem_* outputs held constant from latched values until handshake.
  - Each cycle with mem_ready=0: stay in REQ, wb_valid=0.
  - Edge with mem_ready=1: WB regs load wb_valid=1, wb_rd, wb_reg_write (forced 0 for stores). wb_data = extended load data (stores: 0). Return to IDLE.
  - ex_flush is ignored; an issued access always completes.
- Minimum memory-op latency: accept edge → REQ cycle → result on wb_* after 2nd edge. A new op may be accepted in the first IDLE cycle after REQ.
- Store formatting, o = addr[1:0]:
  - B: wstrb = 4'b0001<<o; wdata = {4{rs2[7:0]}}.
  - H: wstrb = 4'b0011<<(2*addr[1]); wdata = {2{rs2[15:0]}}.
  - W: wstrb = 4'b1111; wdata = rs2.
- Load extraction: byte lane rdata[8*o+:8]; half lane rdata[16*addr[1]+:16].
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - W: pass-through.
- mem_we=0, mem_wstrb=0 for loads. mem_wdata/mem_wstrb=0 whenever mem_req=0.
- Unsupported funct3 on a memory op (011, 110, 111): treated as misaligned (no access, wb_misalign=1).

Decomposition:
- Shared package: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum type lsu_state_t {IDLE, REQ}, DATA_WIDTH/REG_ADDR_W defaults.
- One natural sub-module: lsu_align, purely combinational. It covers store strobe/replication, load extraction/extension and the misalign check; instantiated once for stores and once for loads.

Test Plan:
- Non-memory: ex_valid, wb_data=0x0000_1234, rd=5, reg_write=1 → next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, stall_o never 1.
- SB, addr 0x103, rs2=0xAABB_CCDD → mem_req=1, we=1, addr=0x100, wstrb=1000, wdata=0xDDDD_DDDD. mem_ready after 3 wait cycles → stall_o high exactly 4 cycles, wb_reg_write=0.
- LB, addr 0x202, rdata=0x0080_0000, mem_ready immediate → wb_data=0xFFFF_FF80. LBU same → 0x0000_0080. LHU, addr 0x202, rdata=0xBEEF_0000 → 0x0000_BEEF.
- LW, addr 0x301 → no mem_req; next cycle wb_valid=1, wb_misalign=1, wb_reg_write=0.
- Flush: ex_flush with a valid SW in IDLE → no request, wb_valid=0. ex_flush asserted during REQ → access still completes and writes back.
- Reset: rst_n low while in REQ with mem_ready=0 → mem_req, stall_o, wb_* drop to 0 asynchronously. After release, state is IDLE and a new LW completes normally.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// rtl/mem_stage_lsu_pkg.sv - shared types and constants for the memory-stage LSU
package mem_stage_lsu_pkg;

  localparam int LSU_DATA_WIDTH = 32;
  localparam int LSU_ADDR_WIDTH = 32;
  localparam int LSU_REG_ADDR_W = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// rtl/mem_stage_lsu_align.sv - store lane formatting, load extraction/extension, misalign check
module lsu_align
  import mem_stage_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = LSU_DATA_WIDTH
) (
  input  logic [1:0]            addr_lo,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [3:0]            wstrb,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_result,
  output logic                  misalign
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign load_byte = load_data[{addr_lo, 3'b000} +: 8];
  assign load_half = load_data[{addr_lo[1], 4'b0000} +: 16];

  // Unsupported encodings are reported as misaligned so no access is issued.
  always_comb begin
    misalign = 1'b0;
    case (funct3)
      F3_B, F3_BU: misalign = 1'b0;
      F3_H, F3_HU: misalign = addr_lo[0];
      F3_W:        misalign = (addr_lo != 2'b00);
      default:     misalign = 1'b1;
    endcase
  end

  always_comb begin
    wstrb = 4'b0000;
    wdata = '0;
    case (funct3[1:0])
      2'b00: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        wstrb = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      2'b10: begin
        wstrb = 4'b1111;
        wdata = store_data;
      end
      default: begin
        wstrb = 4'b0000;
        wdata = '0;
      end
    endcase
  end

  always_comb begin
    load_result = '0;
    case (funct3)
      F3_B:    load_result = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
      F3_H:    load_result = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
      F3_W:    load_result = load_data;
      F3_BU:   load_result = {{(DATA_WIDTH-8){1'b0}}, load_byte};
      F3_HU:   load_result = {{(DATA_WIDTH-16){1'b0}}, load_half};
      default: load_result = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory-stage load/store unit with MEM/WB pipeline register
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = LSU_DATA_WIDTH,
  parameter int ADDR_WIDTH = LSU_ADDR_WIDTH,
  parameter int REG_ADDR_W = LSU_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic                  ex_flush,
  input  logic [DATA_WIDTH-1:0] ex_alu_o,
  input  logic [DATA_WIDTH-1:0] ex_wb_data,
  input  logic [DATA_WIDTH-1:0] ex_rs2,
  input  logic [2:0]            ex_funct3,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  stall_o,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_misalign
);

  lsu_state_t            state;
  logic [2:0]            lat_funct3;
  logic [1:0]            lat_addr_lo;
  logic [REG_ADDR_W-1:0] lat_rd;
  logic                  lat_reg_write;

  logic                  accept;
  logic                  is_mem;
  logic                  ex_misalign;
  logic [3:0]            ex_wstrb;
  logic [DATA_WIDTH-1:0] ex_wdata;
  logic [DATA_WIDTH-1:0] ld_result;
  logic [DATA_WIDTH-1:0] unused_ex_load;
  logic [DATA_WIDTH-1:0] unused_ld_wdata;
  logic [3:0]            unused_ld_wstrb;
  logic                  unused_ld_misalign;

  assign accept  = ex_valid & ~ex_flush;
  assign is_mem  = ex_mem_read | ex_mem_write;
  assign stall_o = (state == REQ);

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align_store (
    .addr_lo     (ex_alu_o[1:0]),
    .funct3      (ex_funct3),
    .store_data  (ex_rs2),
    .load_data   ('0),
    .wstrb       (ex_wstrb),
    .wdata       (ex_wdata),
    .load_result (unused_ex_load),
    .misalign    (ex_misalign)
  );

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align_load (
    .addr_lo     (lat_addr_lo),
    .funct3      (lat_funct3),
    .store_data  ('0),
    .load_data   (mem_rdata),
    .wstrb       (unused_ld_wstrb),
    .wdata       (unused_ld_wdata),
    .load_result (ld_result),
    .misalign    (unused_ld_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wstrb     <= 4'b0000;
      lat_funct3    <= 3'b000;
      lat_addr_lo   <= 2'b00;
      lat_rd        <= '0;
      lat_reg_write <= 1'b0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      wb_misalign   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wb_misalign <= 1'b0;
          if (accept && is_mem && ex_misalign) begin
            wb_valid     <= 1'b1;
            wb_misalign  <= 1'b1;
            wb_reg_write <= 1'b0;
            wb_rd        <= ex_rd;
            wb_data      <= '0;
          end else if (accept && is_mem) begin
            // A set write bit wins over read, so read+write is issued as a store.
            state         <= REQ;
            mem_req       <= 1'b1;
            mem_we        <= ex_mem_write;
            mem_addr      <= {ex_alu_o[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata     <= ex_mem_write ? ex_wdata : '0;
            mem_wstrb     <= ex_mem_write ? ex_wstrb : 4'b0000;
            lat_funct3    <= ex_funct3;
            lat_addr_lo   <= ex_alu_o[1:0];
            lat_rd        <= ex_rd;
            lat_reg_write <= ex_reg_write;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
          end else if (accept) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= ex_reg_write;
            wb_rd        <= ex_rd;
            wb_data      <= ex_wb_data;
          end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
          end
        end
        REQ: begin
          wb_misalign <= 1'b0;
          if (mem_ready) begin
            state        <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= 4'b0000;
            wb_valid     <= 1'b1;
            wb_rd        <= lat_rd;
            wb_reg_write <= lat_reg_write & ~mem_we;
            wb_data      <= mem_we ? '0 : ld_result;
          end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_flush;
  logic [31:0] ex_alu_o, ex_wb_data, ex_rs2;
  logic [2:0]  ex_funct3;
  logic        ex_mem_read, ex_mem_write, ex_reg_write;
  logic [4:0]  ex_rd;
  logic        stall_o, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_misalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_flush(ex_flush), .ex_alu_o(ex_alu_o),
    .ex_wb_data(ex_wb_data), .ex_rs2(ex_rs2), .ex_funct3(ex_funct3),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .stall_o(stall_o), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_misalign(wb_misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [31:0] addr, input logic [2:0] f3, input logic rd_en,
                       input logic wr_en, input logic [4:0] rd);
    ex_valid     = 1'b1;
    ex_alu_o     = addr;
    ex_funct3    = f3;
    ex_mem_read  = rd_en;
    ex_mem_write = wr_en;
    ex_reg_write = 1'b1;
    ex_rd        = rd;
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] rs2, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata, input int waits);
    int stall_cnt;
    offer(addr, f3, 1'b0, 1'b1, 5'd7);
    ex_rs2 = rs2;
    mem_ready = 1'b0;
    @(negedge clk);
    chk({tag, " req"}, mem_req, 1);
    chk({tag, " we"}, mem_we, 1);
    chk({tag, " addr"}, mem_addr, {addr[31:2], 2'b00});
    chk({tag, " wstrb"}, mem_wstrb, exp_strb);
    chk({tag, " wdata"}, mem_wdata, exp_wdata);
    chk({tag, " bubble"}, wb_valid, 0);
    stall_cnt = stall_o;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      stall_cnt += stall_o;
      chk({tag, " held addr"}, mem_addr, {addr[31:2], 2'b00});
    end
    mem_ready = 1'b1;
    ex_valid  = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
    chk({tag, " stall cycles"}, stall_cnt, waits + 1);
    chk({tag, " stall off"}, stall_o, 0);
    chk({tag, " req off"}, mem_req, 0);
    chk({tag, " wstrb off"}, mem_wstrb, 0);
    chk({tag, " wb_valid"}, wb_valid, 1);
    chk({tag, " wb_reg_write"}, wb_reg_write, 0);
    chk({tag, " wb_rd"}, wb_rd, 7);
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] rdata, input logic [31:0] exp);
    offer(addr, f3, 1'b1, 1'b0, 5'd9);
    @(negedge clk);
    chk({tag, " req"}, mem_req, 1);
    chk({tag, " we"}, mem_we, 0);
    chk({tag, " addr"}, mem_addr, {addr[31:2], 2'b00});
    chk({tag, " wstrb"}, mem_wstrb, 0);
    mem_ready = 1'b1;
    mem_rdata = rdata;
    ex_valid  = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
    chk({tag, " wb_valid"}, wb_valid, 1);
    chk({tag, " wb_data"}, wb_data, exp);
    chk({tag, " wb_reg_write"}, wb_reg_write, 1);
    chk({tag, " wb_rd"}, wb_rd, 9);
  endtask

  task automatic do_misalign(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                             input logic wr_en);
    offer(addr, f3, ~wr_en, wr_en, 5'd3);
    @(negedge clk);
    chk({tag, " no req"}, mem_req, 0);
    chk({tag, " stall"}, stall_o, 0);
    chk({tag, " wb_valid"}, wb_valid, 1);
    chk({tag, " wb_misalign"}, wb_misalign, 1);
    chk({tag, " wb_reg_write"}, wb_reg_write, 0);
    ex_valid = 1'b0;
    @(negedge clk);
    chk({tag, " misalign pulse"}, wb_misalign, 0);
    chk({tag, " wb_valid off"}, wb_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 0; ex_flush = 0; ex_alu_o = 0; ex_wb_data = 0; ex_rs2 = 0;
    ex_funct3 = 0; ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0; ex_rd = 0;
    mem_ready = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst mem_req", mem_req, 0);
    chk("rst stall", stall_o, 0);
    chk("rst wb_valid", wb_valid, 0);
    chk("rst wb_data", wb_data, 0);
    chk("rst mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Non-memory op
    offer(32'h0, 3'b000, 1'b0, 1'b0, 5'd5);
    ex_wb_data = 32'h0000_1234;
    chk("alu stall", stall_o, 0);
    @(negedge clk);
    chk("alu wb_valid", wb_valid, 1);
    chk("alu wb_data", wb_data, 32'h0000_1234);
    chk("alu wb_rd", wb_rd, 5);
    chk("alu wb_reg_write", wb_reg_write, 1);
    chk("alu stall after", stall_o, 0);
    chk("alu no req", mem_req, 0);
    ex_valid = 1'b0;
    @(negedge clk);
    chk("idle wb_valid", wb_valid, 0);

    do_store("sb", 32'h0000_0103, 3'b000, 32'hAABB_CCDD, 4'b1000, 32'hDDDD_DDDD, 3);
    do_store("sh", 32'h0000_0102, 3'b001, 32'h1122_3344, 4'b1100, 32'h3344_3344, 0);
    do_store("sw", 32'h0000_0104, 3'b010, 32'h1122_3344, 4'b1111, 32'h1122_3344, 1);

    do_load("lb",  32'h0000_0202, 3'b000, 32'h0080_0000, 32'hFFFF_FF80);
    do_load("lbu", 32'h0000_0202, 3'b100, 32'h0080_0000, 32'h0000_0080);
    do_load("lhu", 32'h0000_0202, 3'b101, 32'hBEEF_0000, 32'h0000_BEEF);
    do_load("lh",  32'h0000_0200, 3'b001, 32'h0000_8001, 32'hFFFF_8001);
    do_load("lw",  32'h0000_0300, 3'b010, 32'h1234_5678, 32'h1234_5678);

    do_misalign("lw mis", 32'h0000_0301, 3'b010, 1'b0);
    do_misalign("sh mis", 32'h0000_0101, 3'b001, 1'b1);
    do_misalign("f3 011", 32'h0000_0100, 3'b011, 1'b0);

    // Flush in IDLE kills the offered store
    offer(32'h0000_0400, 3'b010, 1'b0, 1'b1, 5'd4);
    ex_flush = 1'b1;
    @(negedge clk);
    chk("flush no req", mem_req, 0);
    chk("flush wb_valid", wb_valid, 0);
    chk("flush stall", stall_o, 0);
    ex_valid = 1'b0;
    ex_flush = 1'b0;

    // Flush during REQ is ignored
    offer(32'h0000_0500, 3'b010, 1'b1, 1'b0, 5'd9);
    @(negedge clk);
    chk("reqflush req", mem_req, 1);
    ex_flush  = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_ready = 1'b0;
    ex_valid  = 1'b0;
    ex_flush  = 1'b0;
    chk("reqflush wb_valid", wb_valid, 1);
    chk("reqflush wb_data", wb_data, 32'hCAFE_F00D);

    // Async reset in the middle of an access
    offer(32'h0000_0600, 3'b010, 1'b1, 1'b0, 5'd9);
    @(negedge clk);
    chk("prerst req", mem_req, 1);
    chk("prerst stall", stall_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst req", mem_req, 0);
    chk("midrst stall", stall_o, 0);
    chk("midrst addr", mem_addr, 0);
    chk("midrst wb_valid", wb_valid, 0);
    chk("midrst wb_data", wb_data, 0);
    ex_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst stall", stall_o, 0);
    do_load("postrst lw", 32'h0000_0700, 3'b010, 32'h0BAD_BEEF, 32'h0BAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
